// File: rtl/av_mem_slave.sv
// Avalon-MM slave memory model with a fixed-latency read pipeline and a small
// control window (IRQ set/clear, scratch, ID) that drives the BFM's irq vector.
module av_mem_slave #(
  parameter int              ADDRWIDTH    = 32,
  parameter int              DATAWIDTH    = 32,
  parameter int              MEMWORDSBITS = 12,
  parameter int              RDLATENCY    = 2,
  parameter int              IRQWIDTH     = 32,
  parameter logic [31:0]     CTRLBASE     = 32'hAFFFFFF0
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [ADDRWIDTH-1:0]   av_address,
  input  logic [DATAWIDTH/8-1:0] av_byteenable,
  input  logic                   av_write,
  input  logic [DATAWIDTH-1:0]   av_writedata,
  input  logic                   av_read,
  output logic [DATAWIDTH-1:0]   av_readdata,
  output logic                   av_readdatavalid,
  output logic [IRQWIDTH-1:0]    irq
);

  localparam int                   NUMLANES = DATAWIDTH / 8;
  localparam int                   MEMWORDS = 1 << MEMWORDSBITS;
  localparam logic [DATAWIDTH-1:0] ID_VALUE = 32'h41564D53;

  typedef enum logic [1:0] {
    REG_IRQ_SET = 2'd0,
    REG_IRQ_CLR = 2'd1,
    REG_SCRATCH = 2'd2,
    REG_ID      = 2'd3
  } reg_off_t;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } stage_state_t;

  logic                    ctrl_hit;
  reg_off_t                reg_off;
  logic [MEMWORDSBITS-1:0] word_idx;
  logic [DATAWIDTH-1:0]    scratch;
  logic [DATAWIDTH-1:0]    irq_word;
  logic [DATAWIDTH-1:0]    rd_data;
  logic                    unused_addr_bits;

  // Memory starts zeroed at time 0 only; reset deliberately leaves it alone.
  logic [DATAWIDTH-1:0]    mem [MEMWORDS] = '{default: '0};

  stage_state_t            stage_state [RDLATENCY];
  logic [DATAWIDTH-1:0]    stage_data  [RDLATENCY];

  assign ctrl_hit         = (av_address[ADDRWIDTH-1:4] == CTRLBASE[ADDRWIDTH-1:4]);
  assign reg_off          = reg_off_t'(av_address[3:2]);
  assign word_idx         = av_address[MEMWORDSBITS+1:2];
  assign unused_addr_bits = ^av_address[1:0];

  always_comb begin
    irq_word                = '0;
    irq_word[IRQWIDTH-1:0]  = irq;
  end

  always_ff @(posedge clk) begin
    if (nreset && av_write && !ctrl_hit) begin
      for (int b = 0; b < NUMLANES; b++) begin
        if (av_byteenable[b]) begin
          mem[word_idx][8*b +: 8] <= av_writedata[8*b +: 8];
        end
      end
    end
  end

  // IRQ set/clear use the whole word regardless of byteenable.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      irq     <= '0;
      scratch <= '0;
    end else if (av_write && ctrl_hit) begin
      case (reg_off)
        REG_IRQ_SET: irq <= irq | av_writedata[IRQWIDTH-1:0];
        REG_IRQ_CLR: irq <= irq & ~av_writedata[IRQWIDTH-1:0];
        REG_SCRATCH: begin
          for (int b = 0; b < NUMLANES; b++) begin
            if (av_byteenable[b]) begin
              scratch[8*b +: 8] <= av_writedata[8*b +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = mem[word_idx];
    if (ctrl_hit) begin
      case (reg_off)
        REG_IRQ_SET, REG_IRQ_CLR: rd_data = irq_word;
        REG_SCRATCH:              rd_data = scratch;
        default:                  rd_data = ID_VALUE;
      endcase
    end
  end

  // Data is captured at the request edge, so a same-cycle write is not yet visible.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < RDLATENCY; i++) begin
        stage_state[i] <= EMPTY;
        stage_data[i]  <= '0;
      end
    end else begin
      if (av_read) begin
        stage_state[0] <= LOADED;
        stage_data[0]  <= rd_data;
      end else begin
        stage_state[0] <= EMPTY;
        stage_data[0]  <= '0;
      end
      for (int i = 1; i < RDLATENCY; i++) begin
        stage_state[i] <= stage_state[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign av_readdatavalid = (stage_state[RDLATENCY-1] == LOADED);
  assign av_readdata      = av_readdatavalid ? stage_data[RDLATENCY-1] : '0;

endmodule
